// File: rtl/button_packetizer.sv
// button_packetizer
//   Turns controller button samples into 4-word payload bursts for a network
//   TX stack. A burst goes out when the button byte changes, or as a keepalive
//   when nothing has changed for KEEPALIVE_CYCLES. Each burst is followed by a
//   dead time of GAP_CYCLES so the downstream frame can drain.
//
//   Burst format (one word per cycle, axiov high):
//     W0 = MAGIC
//     W1 = {seq, snap}
//     W2 = {7'd0, is_keepalive, prev}
//     W3 = W0 ^ W1 ^ W2            (axiolast high)
//
// Ports
//   clk      in   sole clock
//   rst_n    in   asynchronous active-low reset
//   axiiv    in   button sample valid
//   axiid    in   [7:0] button byte, 1 = pressed
//   axiov    out  payload word valid
//   axiod    out  [15:0] payload word
//   axiolast out  final word of the burst
module button_packetizer #(
  parameter int          KEEPALIVE_CYCLES = 5_000_000,
  parameter int          GAP_CYCLES       = 2048,
  parameter logic [15:0] MAGIC            = 16'hB7E5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        axiiv,
  input  logic [7:0]  axiid,
  output logic        axiov,
  output logic [15:0] axiod,
  output logic        axiolast
);

  localparam int KA_W  = $clog2(KEEPALIVE_CYCLES) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1) + 1;

  localparam logic [KA_W-1:0]  KA_MAX   = KA_W'(KEEPALIVE_CYCLES - 1);
  // Only used when GAP_CYCLES > 0; clamped so the constant stays non-negative.
  localparam int               GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_LAST_I);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [7:0]         latest;
  logic [7:0]         last_sent;
  logic [7:0]         snap;
  logic [7:0]         prev;
  logic [7:0]         seq;
  logic               is_keepalive;
  logic [KA_W-1:0]    ka_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [1:0]         word_idx;
  // Low for the first edge after reset release so that edge can never start
  // a burst, even with a degenerate keepalive period.
  logic               armed;

  logic               change;
  logic               ka_expired;
  logic               trigger;
  logic [15:0]        w1;
  logic [15:0]        w2;
  logic [15:0]        w3;

  assign change     = (latest != last_sent);
  assign ka_expired = (ka_cnt >= KA_MAX);

  assign w1 = {seq, snap};
  assign w2 = {7'd0, is_keepalive, prev};
  assign w3 = MAGIC ^ w1 ^ w2;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and outputs. Outputs decode from registered state only, so
  // the asynchronous reset clears them immediately.
  always_comb begin
    state_next = state;
    trigger    = 1'b0;
    axiov      = 1'b0;
    axiod      = 16'd0;
    axiolast   = 1'b0;
    case (state)
      IDLE: begin
        if (armed && (change || ka_expired)) begin
          trigger    = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        axiov = 1'b1;
        case (word_idx)
          2'd0:    axiod = MAGIC;
          2'd1:    axiod = w1;
          2'd2:    axiod = w2;
          default: begin
            axiod    = w3;
            axiolast = 1'b1;
            state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        endcase
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: sample capture, burst snapshot, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latest       <= 8'd0;
      last_sent    <= 8'd0;
      snap         <= 8'd0;
      prev         <= 8'd0;
      seq          <= 8'd0;
      is_keepalive <= 1'b0;
      ka_cnt       <= '0;
      gap_cnt      <= '0;
      word_idx     <= 2'd0;
      armed        <= 1'b0;
    end else begin
      armed <= 1'b1;

      // Samples keep landing during SEND/GAP; only the value present when
      // IDLE is re-entered matters, so intermediate values simply overwrite.
      if (axiiv) begin
        latest <= axiid;
      end

      if (trigger) begin
        snap         <= latest;
        prev         <= last_sent;
        last_sent    <= latest;
        // A change wins over a simultaneous keepalive expiry.
        is_keepalive <= ~change;
        ka_cnt       <= '0;
        word_idx     <= 2'd0;
      end else if (ka_cnt < KA_MAX) begin
        ka_cnt <= ka_cnt + KA_W'(1);
      end

      if (state == SEND) begin
        word_idx <= word_idx + 2'd1;
        gap_cnt  <= '0;
        // seq advances only once the burst fully completes.
        if (word_idx == 2'd3) begin
          seq <= seq + 8'd1;
        end
      end

      if (state == GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_button_packetizer.sv
module tb_button_packetizer;

  localparam int          K     = 100;
  localparam int          G     = 8;
  localparam logic [15:0] MAGIC = 16'hB7E5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        axiiv = 1'b0;
  logic [7:0]  axiid = 8'd0;
  logic        axiov;
  logic [15:0] axiod;
  logic        axiolast;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  button_packetizer #(
    .KEEPALIVE_CYCLES(K),
    .GAP_CYCLES(G),
    .MAGIC(MAGIC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .axiiv(axiiv),
    .axiid(axiid),
    .axiov(axiov),
    .axiod(axiod),
    .axiolast(axiolast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // ---------------- behavioural model ----------------
  // Tracks the specification-level quantities and a queue of words that are
  // due on the output, one popped per cycle.
  logic [7:0]  m_latest = 0, m_last_sent = 0, m_seq = 0;
  int          m_ka = 0, m_busy = 0;
  bit          m_armed = 0;
  logic [15:0] m_q[$];
  logic        exp_v = 0, exp_l = 0;
  logic [15:0] exp_d = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_latest = 0; m_last_sent = 0; m_seq = 0; m_ka = 0; m_busy = 0;
      m_armed = 0; m_q.delete();
      exp_v = 0; exp_l = 0; exp_d = 0;
    end else begin
      bit          trig;
      bit          ka_flag;
      logic [15:0] w1, w2;
      trig = m_armed && (m_busy == 0) && ((m_latest != m_last_sent) || (m_ka >= K-1));
      if (trig) begin
        ka_flag = (m_latest == m_last_sent);
        w1 = {m_seq, m_latest};
        w2 = {7'd0, ka_flag, m_last_sent};
        m_q.push_back(MAGIC);
        m_q.push_back(w1);
        m_q.push_back(w2);
        m_q.push_back(MAGIC ^ w1 ^ w2);
        m_seq = m_seq + 8'd1;
        m_last_sent = m_latest;
        m_ka = 0;
        m_busy = 4 + G;
      end else begin
        if (m_ka < K-1) m_ka++;
        if (m_busy > 0) m_busy--;
      end
      m_armed = 1;
      if (axiiv) m_latest = axiid;
      if (m_q.size() > 0) begin
        exp_d = m_q.pop_front();
        exp_v = 1;
        exp_l = (m_q.size() == 0);
      end else begin
        exp_d = 0; exp_v = 0; exp_l = 0;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    checks++;
    if (axiov !== exp_v || axiod !== exp_d || axiolast !== exp_l) begin
      failures++;
      $display("FAIL model_cmp cyc=%0d got v=%b d=%h l=%b want v=%b d=%h l=%b",
               cyc, axiov, axiod, axiolast, exp_v, exp_d, exp_l);
    end
  end

  // ---------------- burst monitor ----------------
  logic [15:0] bw [0:511][0:3];
  int          bstart [0:511];
  int          nb = 0;
  logic [15:0] tmp [0:3];
  int          widx = 0;
  int          tstart = 0;

  always @(negedge clk) begin
    if (!rst_n || !axiov) begin
      widx = 0;
    end else begin
      if (widx == 0) tstart = cyc;
      if (widx < 4) tmp[widx] = axiod;
      widx++;
      if (axiolast) begin
        if (widx == 4 && nb < 512) begin
          for (int j = 0; j < 4; j++) bw[nb][j] = tmp[j];
          bstart[nb] = tstart;
          $display("burst %0d start=%0d words %h %h %h %h", nb, tstart, tmp[0], tmp[1], tmp[2], tmp[3]);
          nb++;
        end
        widx = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic wait_bursts(input int n, input int budget);
    int k = 0;
    while (nb < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (nb < n) begin
      failures++;
      $display("FAIL burst_timeout got=%0d want=%0d", nb, n);
    end
  endtask

  task automatic do_reset(output int rel);
    @(negedge clk);
    #1 rst_n = 0;
    axiiv = 0;
    axiid = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    rel = cyc;
  endtask

  task automatic pulse(input logic [7:0] v, output int c);
    @(negedge clk);
    c = cyc;
    axiiv = 1;
    axiid = v;
    @(negedge clk);
    axiiv = 0;
  endtask

  initial begin
    int rel, c, base, s;

    // Reset values while rst_n is low.
    repeat (2) @(negedge clk);
    check_val("reset_axiov", int'(axiov), 0);
    check_val("reset_axiod", int'(axiod), 0);

    // Keepalive-only burst after reset with an unchanged 0x00 input.
    do_reset(rel);
    axiiv = 1;
    axiid = 8'h00;
    base = nb;
    wait_bursts(base + 1, 300);
    check_val("ka_start", bstart[base] - rel, 100);
    check_val("ka_w0", int'(bw[base][0]), 16'hB7E5);
    check_val("ka_w1", int'(bw[base][1]), 16'h0000);
    check_val("ka_w2", int'(bw[base][2]), 16'h0100);
    check_val("ka_w3", int'(bw[base][3]), 16'hB6E5);

    // Single pulse of 0x81 from IDLE.
    axiiv = 0;
    do_reset(rel);
    repeat (3) @(negedge clk);
    base = nb;
    pulse(8'h81, c);
    wait_bursts(base + 1, 40);
    check_val("pulse_latency", bstart[base] - c, 2);
    check_val("pulse_w1", int'(bw[base][1]), 16'h0081);
    check_val("pulse_w2", int'(bw[base][2]), 16'h0000);
    check_val("pulse_w3", int'(bw[base][3]), 16'hB764);

    // Two samples during GAP: only the last one is sent.
    pulse(8'h01, c);
    pulse(8'h02, c);
    wait_bursts(base + 2, 40);
    check_val("gap_w1", int'(bw[base+1][1]), 16'h0102);
    check_val("gap_w2", int'(bw[base+1][2]), 16'h0081);
    check_val("gap_w3", int'(bw[base+1][3]), 16'hB666);
    check_val("gap_spacing_ge13", int'((bstart[base+1] - bstart[base]) >= 13), 1);

    // A -> B -> A within the gap produces nothing.
    pulse(8'h05, c);
    pulse(8'h02, c);
    repeat (40) @(negedge clk);
    check_val("aba_no_burst", nb, base + 2);

    // Sequence wrap over 257 change bursts.
    do_reset(rel);
    base = nb;
    for (int i = 0; i < 257; i++) begin
      pulse((i % 2 == 0) ? 8'h55 : 8'hAA, c);
      wait_bursts(base + i + 1, 40);
    end
    check_val("seq_burst256", int'(bw[base+255][1][15:8]), 8'hFF);
    check_val("seq_burst257", int'(bw[base+256][1][15:8]), 8'h00);

    // Reset in the middle of a burst.
    do_reset(rel);
    repeat (2) @(negedge clk);
    pulse(8'h33, c);
    @(negedge clk);
    @(negedge clk);
    check_val("pre_rst_w1", int'(axiod), 16'h0033);
    #1 rst_n = 0;
    #1;
    check_val("midrst_axiov", int'(axiov), 0);
    check_val("midrst_axiod", int'(axiod), 0);
    check_val("midrst_axiolast", int'(axiolast), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    base = nb;
    pulse(8'h44, c);
    wait_bursts(base + 1, 40);
    check_val("postrst_w1", int'(bw[base][1]), 16'h0044);
    check_val("postrst_w2", int'(bw[base][2]), 16'h0000);

    // Change on the same cycle the keepalive expires.
    do_reset(rel);
    base = nb;
    repeat (98) @(negedge clk);
    axiiv = 1;
    axiid = 8'h3C;
    @(negedge clk);
    axiiv = 0;
    wait_bursts(base + 1, 40);
    s = bstart[base];
    check_val("coinc_start", s - rel, 100);
    check_val("coinc_w1", int'(bw[base][1]), 16'h003C);
    check_val("coinc_w2", int'(bw[base][2]), 16'h0000);
    while (cyc < s + 99) @(posedge clk);
    check_val("coinc_single", nb, base + 1);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
